// File: rtl/cp0_exception_unit_if.sv
// M-stage exception/CP0 bundle between the pipeline and cp0_exception_unit.
// Request fields are sampled by the CP0 in the cycle they are driven; there is no backpressure.
interface cp0_exception_unit_if;
   logic        InstValidM;
   logic [31:0] PCM;
   logic        DelaySlotM;
   logic        BreakM;
   logic        SyscallM;
   logic        ReserveM;
   logic        OverflowM;
   logic        AdelFetchM;
   logic        AdelDataM;
   logic        AdesDataM;
   logic [31:0] BadAddrM;
   logic        EretM;
   logic        CP0WriteM;
   logic [4:0]  CP0WaddrM;
   logic [31:0] CP0WdataM;
   logic [4:0]  CP0RaddrE;
   logic [5:0]  ExtInt;
   logic [31:0] CP0RdataE;
   logic        FlushAllM;
   logic [31:0] RedirectPCM;
   logic        TimerInt;

   modport master (
      output InstValidM, PCM, DelaySlotM, BreakM, SyscallM, ReserveM, OverflowM,
             AdelFetchM, AdelDataM, AdesDataM, BadAddrM, EretM, CP0WriteM,
             CP0WaddrM, CP0WdataM, CP0RaddrE, ExtInt,
      input  CP0RdataE, FlushAllM, RedirectPCM, TimerInt
   );

   modport slave (
      input  InstValidM, PCM, DelaySlotM, BreakM, SyscallM, ReserveM, OverflowM,
             AdelFetchM, AdelDataM, AdesDataM, BadAddrM, EretM, CP0WriteM,
             CP0WaddrM, CP0WdataM, CP0RaddrE, ExtInt,
      output CP0RdataE, FlushAllM, RedirectPCM, TimerInt
   );
endinterface

// File: rtl/cp0_exception_unit.sv
// CP0 register file and precise-exception responder for the MEM stage.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise both read 0 and TI is tied low.
module cp0_exception_unit #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
   input  logic           clk,
   input  logic           rst,
   cp0_exception_unit_if.slave bus
);
   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;

   localparam logic [1:0] BAD_NONE = 2'd0;
   localparam logic [1:0] BAD_PC   = 2'd1;
   localparam logic [1:0] BAD_DATA = 2'd2;

   logic [31:0] status;
   logic        cause_bd;
   logic [7:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;
   logic [31:0] badvaddr;
   logic [31:0] count;
   logic [31:0] compare;
   logic        ti;

   logic        int_pend;
   logic        exc_sel;
   logic [4:0]  exc_code;
   logic [1:0]  bad_sel;
   logic        eret_take;
   logic        wr_commit;
   logic [31:0] cause_word;

   assign int_pend = status[0] & ~status[1] & (|(cause_ip & status[15:8]));

   always_comb begin
      exc_sel  = 1'b0;
      exc_code = 5'd0;
      bad_sel  = BAD_NONE;
      if (bus.InstValidM) begin
         if (int_pend) begin
            exc_sel = 1'b1; exc_code = 5'd0;
         end else if (bus.AdelFetchM) begin
            exc_sel = 1'b1; exc_code = 5'd4; bad_sel = BAD_PC;
         end else if (bus.ReserveM) begin
            exc_sel = 1'b1; exc_code = 5'd10;
         end else if (bus.OverflowM) begin
            exc_sel = 1'b1; exc_code = 5'd12;
         end else if (bus.SyscallM) begin
            exc_sel = 1'b1; exc_code = 5'd8;
         end else if (bus.BreakM) begin
            exc_sel = 1'b1; exc_code = 5'd9;
         end else if (bus.AdelDataM) begin
            exc_sel = 1'b1; exc_code = 5'd4; bad_sel = BAD_DATA;
         end else if (bus.AdesDataM) begin
            exc_sel = 1'b1; exc_code = 5'd5; bad_sel = BAD_DATA;
         end
      end
   end

   // An exception in M suppresses both ERET and MTC0 of the same instruction.
   assign eret_take = bus.InstValidM & bus.EretM & ~exc_sel;
   assign wr_commit = bus.InstValidM & bus.CP0WriteM & ~exc_sel;

   assign bus.FlushAllM   = exc_sel | eret_take;
   assign bus.RedirectPCM = exc_sel ? EXC_VECTOR : epc;
   assign bus.TimerInt    = ti;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status    <= RESET_STATUS;
         cause_bd  <= 1'b0;
         cause_ip  <= 8'd0;
         cause_exc <= 5'd0;
         epc       <= 32'd0;
         badvaddr  <= 32'd0;
      end else begin
         cause_ip[7:2] <= {bus.ExtInt[5] | ti, bus.ExtInt[4:0]};
         if (exc_sel) begin
            cause_exc <= exc_code;
            status[1] <= 1'b1;
            // A nested exception keeps the EPC/BD of the original fault.
            if (!status[1]) begin
               epc      <= bus.DelaySlotM ? (bus.PCM - 32'd4) : bus.PCM;
               cause_bd <= bus.DelaySlotM;
            end
            if (bad_sel == BAD_PC)
               badvaddr <= bus.PCM;
            else if (bad_sel == BAD_DATA)
               badvaddr <= bus.BadAddrM;
         end else begin
            if (eret_take)
               status[1] <= 1'b0;
            if (wr_commit) begin
               case (bus.CP0WaddrM)
                  A_STATUS: begin
                     status[15:8] <= bus.CP0WdataM[15:8];
                     status[1:0]  <= bus.CP0WdataM[1:0];
                  end
                  A_CAUSE:  cause_ip[1:0] <= bus.CP0WdataM[9:8];
                  A_EPC:    epc <= bus.CP0WdataM;
                  default:  ;
               endcase
            end
         end
      end
   end

`ifdef CP0_TIMER_EN
   logic tick;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick    <= 1'b0;
         count   <= 32'd0;
         compare <= 32'd0;
         ti      <= 1'b0;
      end else begin
         tick <= ~tick;
         if (wr_commit && bus.CP0WaddrM == A_COUNT)
            count <= bus.CP0WdataM;
         else if (tick)
            count <= count + 32'd1;
         // Writing Compare acknowledges the timer even if it matches this cycle.
         if (wr_commit && bus.CP0WaddrM == A_COMPARE) begin
            compare <= bus.CP0WdataM;
            ti      <= 1'b0;
         end else if (count == compare && compare != 32'd0) begin
            ti <= 1'b1;
         end
      end
   end
`else
   assign count   = 32'd0;
   assign compare = 32'd0;
   assign ti      = 1'b0;
`endif

   assign cause_word = {cause_bd, ti, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};

   always_comb begin
      case (bus.CP0RaddrE)
         A_BADVADDR: bus.CP0RdataE = badvaddr;
         A_COUNT:    bus.CP0RdataE = count;
         A_COMPARE:  bus.CP0RdataE = compare;
         A_STATUS:   bus.CP0RdataE = status;
         A_CAUSE:    bus.CP0RdataE = cause_word;
         A_EPC:      bus.CP0RdataE = epc;
         default:    bus.CP0RdataE = 32'd0;
      endcase
   end
endmodule
